// File: rtl/ascii_pkg.sv
// rtl/ascii_pkg.sv - shared ASCII constants, status codes and parser state encoding
package ascii_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CHAR = 2'b01;
    localparam logic [1:0] ERR_OVF  = 2'b10;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] EMIT  = 2'd3;

endpackage

// File: rtl/ascii_to_hex.sv
// rtl/ascii_to_hex.sv - combinational ASCII character classifier and hex digit decoder
module ascii_to_hex
    import ascii_pkg::*;
(
    input  logic [7:0] ascii,
    output logic [3:0] nibble,
    output logic       is_digit,
    output logic       is_term
);

    always_comb begin
        nibble   = 4'h0;
        is_digit = 1'b0;
        is_term  = 1'b0;
        if (ascii >= 8'h30 && ascii <= 8'h39) begin
            nibble   = ascii[3:0];
            is_digit = 1'b1;
        end else if ((ascii >= 8'h41 && ascii <= 8'h46) ||
                     (ascii >= 8'h61 && ascii <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
            nibble   = ascii[3:0] + 4'd9;
            is_digit = 1'b1;
        end else if (ascii == ASCII_CR || ascii == ASCII_LF || ascii == ASCII_SP) begin
            is_term  = 1'b1;
        end
    end

endmodule

// File: rtl/ascii_hex_parser.sv
// rtl/ascii_hex_parser.sv - streaming ASCII hex token parser producing binary words with status
module ascii_hex_parser
    import ascii_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    input  logic [7:0]                   i_ASCII,
    output logic                         o_ready,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [4*DIGITS-1:0]          o_value,
    output logic [$clog2(DIGITS+1)-1:0]  o_digits,
    output logic [1:0]                   o_error
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    logic [1:0]    state;
    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic [1:0]    err;

    logic [3:0]    nibble;
    logic          is_digit;
    logic          is_term;
    logic          accept;
    logic          ok_result;

    ascii_to_hex u_ascii_to_hex (
        .ascii    (i_ASCII),
        .nibble   (nibble),
        .is_digit (is_digit),
        .is_term  (is_term)
    );

    assign o_ready = (state != EMIT);
    assign accept  = i_valid && o_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            err   <= ERR_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_digit) begin
                            acc   <= W'(nibble);
                            cnt   <= CW'(1);
                            state <= ACCUM;
                        end else if (!is_term) begin
                            err   <= ERR_CHAR;
                            state <= DRAIN;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (is_digit) begin
                            if (cnt == CW'(DIGITS)) begin
                                err   <= ERR_OVF;
                                state <= DRAIN;
                            end else begin
                                acc <= (acc << 4) | W'(nibble);
                                cnt <= cnt + CW'(1);
                            end
                        end else if (is_term) begin
                            state <= EMIT;
                        end else begin
                            err   <= ERR_CHAR;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // err already holds the first fault; later bytes never overwrite it
                    if (accept && is_term) begin
                        state <= EMIT;
                    end
                end
                default: begin
                    if (i_ready) begin
                        state <= IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                        err   <= ERR_NONE;
                    end
                end
            endcase
        end
    end

    assign o_valid   = (state == EMIT);
    assign ok_result = o_valid && (err == ERR_NONE);
    assign o_value   = ok_result ? acc : '0;
    assign o_digits  = ok_result ? cnt : '0;
    assign o_error   = o_valid ? err : ERR_NONE;

endmodule

// File: tb/tb_ascii_hex_parser.sv
// tb/tb_ascii_hex_parser.sv - self-checking bench for ascii_hex_parser with token-level reference model
module tb_ascii_hex_parser;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int CW     = $clog2(DIGITS + 1);

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_valid;
    logic [7:0]    i_ASCII;
    logic          o_ready;
    logic          o_valid;
    logic          i_ready;
    logic [W-1:0]  o_value;
    logic [CW-1:0] o_digits;
    logic [1:0]    o_error;

    always #5 i_clk = ~i_clk;

    ascii_hex_parser #(.DIGITS(DIGITS)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .i_ASCII  (i_ASCII),
        .o_ready  (o_ready),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_value  (o_value),
        .o_digits (o_digits),
        .o_error  (o_error)
    );

    typedef struct {
        logic [W-1:0] v;
        int           d;
        logic [1:0]   e;
    } res_t;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cycle    = 0;
    int           ready_mode = 1;
    int           vcycles  = 0;
    int           last_xfer = 0;
    int           last_acc  = 0;
    bit           prev_hold = 1'b0;
    logic [W-1:0] pv;
    logic [CW-1:0] pd;
    logic [1:0]   pe;
    res_t         got_q[$];
    res_t         exp_q[$];
    byte unsigned tok[$];

    initial forever begin
        @(posedge i_clk);
        cycle++;
    end

    // Output monitor: drives i_ready, checks hold stability, records transfers
    initial forever begin
        @(negedge i_clk);
        case (ready_mode)
            0:       i_ready = 1'b0;
            1:       i_ready = 1'b1;
            default: i_ready = 1'($urandom_range(0, 1));
        endcase
        if (o_valid) vcycles++;
        if (prev_hold) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_value !== pv || o_digits !== pd || o_error !== pe) begin
                n_fail++;
                $display("FAIL hold_stable: got valid=%b value=%h digits=%0d error=%b, need valid=1 value=%h digits=%0d error=%b",
                         o_valid, o_value, o_digits, o_error, pv, pd, pe);
            end
        end
        prev_hold = o_valid && !i_ready;
        pv = o_value;
        pd = o_digits;
        pe = o_error;
        if (o_valid && i_ready) begin
            got_q.push_back('{o_value, int'(o_digits), o_error});
            last_xfer = cycle + 1;
        end
    end

    function automatic int hexval(byte unsigned c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 'h30;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 'h41 + 10;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 'h61 + 10;
        return -1;
    endfunction

    function automatic bit is_term(byte unsigned c);
        return (c == 8'h0D || c == 8'h0A || c == 8'h20);
    endfunction

    // Whole-token evaluation: first fault by position decides the status
    function automatic void model_feed(byte unsigned c);
        res_t       r;
        int         nd;
        int         val;
        int         h;
        logic [1:0] e;
        if (!is_term(c)) begin
            tok.push_back(c);
            return;
        end
        if (tok.size() == 0) return;
        nd  = 0;
        val = 0;
        e   = 2'b00;
        for (int i = 0; i < tok.size(); i++) begin
            h = hexval(tok[i]);
            if (h < 0) begin
                e = 2'b01;
                break;
            end
            if (nd == DIGITS) begin
                e = 2'b10;
                break;
            end
            val = val * 16 + h;
            nd++;
        end
        if (e != 2'b00) begin
            val = 0;
            nd  = 0;
        end
        r.v = W'(val);
        r.d = nd;
        r.e = e;
        exp_q.push_back(r);
        tok.delete();
    endfunction

    task automatic send_byte(input byte unsigned b);
        bit done = 1'b0;
        i_valid = 1'b1;
        i_ASCII = b;
        for (int k = 0; k < 200 && !done; k++) begin
            if (o_ready === 1'b1) begin
                done     = 1'b1;
                last_acc = cycle + 1;
                model_feed(b);
            end
            @(posedge i_clk);
            @(negedge i_clk);
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_timeout: byte %h not accepted, o_ready=%b, need 1", b, o_ready);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        i_valid = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge i_clk);
            if (got_q.size() >= exp_q.size() && o_valid === 1'b0) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d results, need %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        i_valid = 1'b0;
        i_ASCII = 8'h00;
        i_ready = 1'b1;
        i_rst_n = 1'b0;
        #12;
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_value !== '0 || o_digits !== '0 || o_error !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_values: got ready=%b valid=%b value=%h digits=%0d error=%b, need 1 0 0000 0 00",
                     o_ready, o_valid, o_value, o_digits, o_error);
        end
        i_rst_n = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_value !== '0 || o_error !== 2'b00) begin
            n_fail++;
            $display("FAIL after_reset: got ready=%b valid=%b value=%h error=%b, need 1 0 0000 00",
                     o_ready, o_valid, o_value, o_error);
        end
    endtask

    task automatic test_basic();
        vcycles = 0;
        send_str("1A3F\r");
        drain();
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count: got %0d results, need %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++;
            if (got_q[i].v !== exp_q[i].v || got_q[i].d !== exp_q[i].d || got_q[i].e !== exp_q[i].e) begin
                n_fail++;
                $display("FAIL basic_result[%0d]: got %h/%0d/%b, need %h/%0d/%b", i,
                         got_q[i].v, got_q[i].d, got_q[i].e, exp_q[i].v, exp_q[i].d, exp_q[i].e);
            end
        end
        n_checks++;
        if (vcycles !== 1) begin
            n_fail++;
            $display("FAIL basic_valid_cycles: got %0d, need 1", vcycles);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_tokens(input string name, input string s);
        send_str(s);
        drain();
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d results, need %0d", name, got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++;
            if (got_q[i].v !== exp_q[i].v || got_q[i].d !== exp_q[i].d || got_q[i].e !== exp_q[i].e) begin
                n_fail++;
                $display("FAIL %s_result[%0d]: got %h/%0d/%b, need %h/%0d/%b", name, i,
                         got_q[i].v, got_q[i].d, got_q[i].e, exp_q[i].v, exp_q[i].d, exp_q[i].e);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_stall();
        ready_mode = 0;
        @(negedge i_clk);
        @(negedge i_clk);
        send_str("FF\r");
        i_valid = 1'b1;
        i_ASCII = 8'h33;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_value !== 16'h00FF || o_error !== 2'b00) begin
                n_fail++;
                $display("FAIL stall[%0d]: got valid=%b ready=%b value=%h error=%b, need 1 0 00ff 00",
                         k, o_valid, o_ready, o_value, o_error);
            end
            @(negedge i_clk);
        end
        ready_mode = 1;
        send_byte(8'h33);
        n_checks++;
        if (last_acc !== last_xfer + 1) begin
            n_fail++;
            $display("FAIL stall_accept_edge: got accept at %0d, need %0d", last_acc, last_xfer + 1);
        end
        send_str("\r");
        drain();
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL stall_count: got %0d results, need %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++;
            if (got_q[i].v !== exp_q[i].v || got_q[i].d !== exp_q[i].d || got_q[i].e !== exp_q[i].e) begin
                n_fail++;
                $display("FAIL stall_result[%0d]: got %h/%0d/%b, need %h/%0d/%b", i,
                         got_q[i].v, got_q[i].d, got_q[i].e, exp_q[i].v, exp_q[i].d, exp_q[i].e);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        for (int sc = 0; sc < 2; sc++) begin
            ready_mode = (sc == 0) ? 1 : 0;
            @(negedge i_clk);
            @(negedge i_clk);
            if (sc == 0) send_str("12");
            else         send_str("5\r");
            @(posedge i_clk);
            #2 i_rst_n = 1'b0;
            #1;
            n_checks++;
            if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_value !== '0 || o_digits !== '0 || o_error !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: got ready=%b valid=%b value=%h digits=%0d error=%b, need 1 0 0000 0 00",
                         sc, o_ready, o_valid, o_value, o_digits, o_error);
            end
            #1 i_rst_n = 1'b1;
            prev_hold = 1'b0;
            tok.delete();
            got_q.delete();
            exp_q.delete();
            ready_mode = 1;
            @(negedge i_clk);
        end
        test_tokens("after_reset", "3\r");
    endtask

    task automatic test_random();
        string hex = "0123456789ABCDEFabcdef";
        byte unsigned bad[6]  = '{8'h47, 8'h7A, 8'h2D, 8'h23, 8'h00, 8'hFF};
        byte unsigned term[3] = '{8'h0D, 8'h0A, 8'h20};
        ready_mode = 2;
        for (int t = 0; t < 80; t++) begin
            int len = $urandom_range(0, 6);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 99) < 8) send_byte(bad[$urandom_range(0, 5)]);
                else                            send_byte(hex[$urandom_range(0, 21)]);
                if ($urandom_range(0, 9) == 0) begin
                    i_valid = 1'b0;
                    @(negedge i_clk);
                end
            end
            send_byte(term[$urandom_range(0, 2)]);
        end
        ready_mode = 1;
        test_tokens("random", "");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tokens("empty_tokens", "b2 \r\n");
        test_tokens("overflow", "12345\r7\r");
        test_tokens("illegal", "1G2\rG12345\r");
        test_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
